uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-path controller for the UART RX. It detects the start bit and runs the per-bit edge counter that times the 3-sample majority-vote data sampler. It consumes the voted `sampled_bit` and sequences the frame through start, data, optional parity and stop. It outputs the assembled byte with a valid strobe and error flags to the RX clock-domain logic.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame, LSB first.

Ports:
- `CLK`  in  1  oversampling clock (PRESCALE × baud).
- `RST`  in  1  reset; asynchronous, active-low.
- `RX_IN`  in  1  serial line, idle high.
- `PRESCALE`  in  6  oversampling ratio; 8, 16 or 32; any other value is treated as 8.
- `PAR_EN`  in  1  parity bit present in frame.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `sampled_bit`  in  1  majority-voted bit from the sampler.
- `data_samp_en`  out  1  sampler enable.
- `edge_cnt`  out  6  oversample edge index within the current bit, 0..P-1.
- `P_DATA`  out  DATA_W  received byte.
- `data_valid`  out  1  one-cycle strobe, frame accepted.
- `par_err`  out  1  parity mismatch on the last frame.
- `stp_err`  out  1  stop bit sampled low on the last frame.

## Operation
- The effective prescale P is decoded from `PRESCALE`: 8, 16, 32, else 8.
- `PRESCALE`, `PAR_EN` and `PAR_TYP` are latched on the IDLE→START transition. Changes mid-frame are ignored.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- **IDLE**
  - `edge_cnt` = 0, `data_samp_en` = 0.
  - When `RX_IN` = 0, go to START. This cycle counts as edge 0.
  - On this transition, `par_err` and `stp_err` are cleared.
- **Common to all non-IDLE states**
  - `data_samp_en` = 1.
  - `edge_cnt` increments every cycle and wraps P-1→0.
  - All bit decisions are taken in the cycle with `edge_cnt` = P-1.
- **START**
  - At P-1, if `sampled_bit` = 0, go to DATA with bit counter = 0.
  - Otherwise the start was a glitch: go to IDLE with no flags and no strobe.
- **DATA**
  - At each P-1, shift `sampled_bit` into the MSB of the shift register (right shift, LSB-first assembly) and increment the bit counter.
  - After bit DATA_W-1, go to PARITY if the latched `PAR_EN` is set, else to STOP.
- **PARITY**
  - Expected bit = XOR of data (even) or its inverse (odd).
  - At P-1, set `par_err` = (`sampled_bit` ≠ expected). Go to STOP.
- **STOP**
  - At P-1, set `stp_err` = ~`sampled_bit`. Go to IDLE.
  - If neither error is set, load the shift register into `P_DATA` and pulse `data_valid`.
  - On error, `P_DATA` holds its previous value and there is no strobe.
- **Back-to-back frames:** IDLE lasts at least one cycle. A low `RX_IN` in that cycle starts the next frame.
- **Reset mid-frame:** return to IDLE immediately. Partial data is discarded.

## Timing
- **Reset values:** `data_samp_en` = 0, `edge_cnt` = 0, `P_DATA` = 0, `data_valid` = 0, `par_err` = 0, `stp_err` = 0, state IDLE.
- **Edge numbering:** start detected at cycle T0 (edge 0). Frame length N = 1 + DATA_W + PAR_EN + 1 bits.
  - `data_valid` is high at cycle T0 + N·P, for exactly 1 cycle.
  - `P_DATA` and the error flags update in that same cycle.
- **Sampler contract:**
  - The sampler captures at edges P/2-1, P/2 and P/2+1.
  - `sampled_bit` is stable by edge P/2+3, which is ≤ P-1 for P = 8.
  - The controller must not read `sampled_bit` at any other edge.
- **Data timing:** `data_samp_en` rises in the cycle after T0, with `edge_cnt` = 1, and falls in the first IDLE cycle.
- **Error flags:** held until the next valid start is detected.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: PARITY state and parity checking as described.
- Undefined:
  - PARITY state and checker are not synthesized.
  - `PAR_EN` and `PAR_TYP` are ignored.
  - DATA always goes to STOP.
  - `par_err` is tied to 0.
  - Frame N = DATA_W + 2.

## Test plan
- **P = 8, no parity, byte 0xA5 with stop = 1:** `data_valid` high only at T0+80; `P_DATA` = 0xA5; no error flags.
- **P = 16, even parity, byte 0x3C with parity bit 0:** `data_valid` at T0+176; `P_DATA` = 0x3C; `par_err` = 0. Repeat with parity bit 1: no strobe, `par_err` = 1, `P_DATA` unchanged.
- **P = 32, odd parity, byte 0x01 with parity 0, stop bit driven 0:** `stp_err` = 1; no strobe.
- **Start glitch:** `RX_IN` low for 2 cycles only at P = 8. Return to IDLE at T0+7; `data_valid` = 0; flags unchanged.
- **Back-to-back frames 0x55 then 0xAA at P = 8, no idle gap:** two strobes 80 cycles apart, with correct bytes.
- **`RST` low at the 4th data bit:** all outputs return to reset values immediately. The next clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: start detect, per-bit edge counter, LSB-first data, optional parity, stop.
// Latency: byte, flags and one-cycle strobe registered N*P cycles after the start edge; no backpressure.
// Parity state and checker exist only when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [5:0]        PRESCALE,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              sampled_bit,
  output logic              data_samp_en,
  output logic [5:0]        edge_cnt,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state, state_n;
  logic [5:0]        edge_n, p_last, plast_n, p_dec;
  logic              en_n, dv_n, serr_n, at_last;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, sh_n, pdata_n;
`ifdef UART_RX_PARITY_EN
  logic              par_en_q, par_typ_q, paren_n, partyp_n, perr_n;
`endif

  always_comb begin
    case (PRESCALE)
      6'd16:   p_dec = 6'd15;
      6'd32:   p_dec = 6'd31;
      default: p_dec = 6'd7;
    endcase
  end

  assign at_last = (edge_cnt == p_last);

  always_comb begin
    state_n = state;
    edge_n  = at_last ? 6'd0 : edge_cnt + 6'd1;
    en_n    = 1'b1;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    pdata_n = P_DATA;
    dv_n    = 1'b0;
    serr_n  = stp_err;
    plast_n = p_last;
`ifdef UART_RX_PARITY_EN
    paren_n  = par_en_q;
    partyp_n = par_typ_q;
    perr_n   = par_err;
`endif
    case (state)
      IDLE: begin
        edge_n = 6'd0;
        en_n   = 1'b0;
        if (!RX_IN) begin
          // The detection cycle is edge 0, so the counter enters START at 1.
          state_n = START;
          edge_n  = 6'd1;
          en_n    = 1'b1;
          serr_n  = 1'b0;
          plast_n = p_dec;
`ifdef UART_RX_PARITY_EN
          perr_n   = 1'b0;
          paren_n  = PAR_EN;
          partyp_n = PAR_TYP;
`endif
        end
      end
      START: begin
        if (at_last) begin
          if (!sampled_bit) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
            en_n    = 1'b0;
          end
        end
      end
      DATA: begin
        if (at_last) begin
          sh_n  = {sampled_bit, shreg[DATA_W-1:1]};
          bit_n = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = par_en_q ? PARITY : STOP;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_last) begin
          perr_n  = (sampled_bit != (^shreg ^ par_typ_q));
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (at_last) begin
          serr_n  = ~sampled_bit;
          state_n = IDLE;
          en_n    = 1'b0;
          if (!par_err && sampled_bit) begin
            pdata_n = shreg;
            dv_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        edge_n  = 6'd0;
        en_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      edge_cnt     <= 6'd0;
      data_samp_en <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      stp_err      <= 1'b0;
      p_last       <= 6'd7;
    end else begin
      state        <= state_n;
      edge_cnt     <= edge_n;
      data_samp_en <= en_n;
      bit_cnt      <= bit_n;
      shreg        <= sh_n;
      P_DATA       <= pdata_n;
      data_valid   <= dv_n;
      stp_err      <= serr_n;
      p_last       <= plast_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_en_q  <= paren_n;
      par_typ_q <= partyp_n;
      par_err   <= perr_n;
    end
  end
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, models the 3-sample voter, scoreboards strobes.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN, PAR_TYP, sampled_bit;
  logic       data_samp_en;
  logic [5:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_samp_en(data_samp_en),
    .edge_cnt(edge_cnt), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cur_p = 8;

  // Voter model: captures the line at edges P/2-1..P/2+1, majority is valid afterwards.
  logic [2:0] samp = 3'b111;
  always @(posedge CLK)
    if (data_samp_en && int'(edge_cnt) >= cur_p / 2 - 1 && int'(edge_cnt) <= cur_p / 2 + 1)
      samp <= {samp[1:0], RX_IN};
  assign sampled_bit = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  dat;
    logic        pe;
    logic        se;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic       se_log [512];
  logic [5:0] ec_log [512];
  logic [1:0] fl_log [512];

  // Cycle c is the c-th cycle after the first low line cycle (T0 = cycle 0).
  task automatic send(input logic [63:0] bits, input int nbits, input int ncyc, input bit scramble);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      if (c < 512) begin
        se_log[c] = data_samp_en;
        ec_log[c] = edge_cnt;
        fl_log[c] = {par_err, stp_err};
      end
      if (data_valid) obs_q.push_back(ev_t'({16'(c), P_DATA, par_err, stp_err}));
      RX_IN = (c < nbits * cur_p) ? bits[c / cur_p] : 1'b1;
      if (scramble && c == 3) begin
        PRESCALE = 6'd32;
        PAR_EN   = ~PAR_EN;
        PAR_TYP  = ~PAR_TYP;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err} !== 18'h0) begin
      failures++;
      $display("FAIL reset_values: got %h want 0",
               {data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err});
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({data_samp_en, edge_cnt, data_valid} !== 8'h0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h want 0", {data_samp_en, edge_cnt, data_valid});
    end
  endtask

  task automatic test_basic();
    ev_t e, o;
    cur_p = 8; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    exp_q.push_back(ev_t'({16'd80, 8'hA5, 1'b0, 1'b0}));
    send(64'({1'b1, 8'hA5, 1'b0}), 10, 84, 1'b1);
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_strobe: got cyc=%0d byte=%h pe=%b se=%b want cyc=%0d byte=%h pe=%b se=%b",
                 o.cyc, o.dat, o.pe, o.se, e.cyc, e.dat, e.pe, e.se);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL basic_extra: got %0d extra strobes want 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if ({se_log[0], se_log[1], ec_log[1]} !== {1'b0, 1'b1, 6'd1}) begin
      failures++;
      $display("FAIL basic_samp_en_rise: got en0=%b en1=%b edge1=%0d want 0 1 1", se_log[0], se_log[1], ec_log[1]);
    end
    checks++;
    if ({ec_log[7], ec_log[8], ec_log[79]} !== {6'd7, 6'd0, 6'd7}) begin
      failures++;
      $display("FAIL basic_edge_wrap: got %0d %0d %0d want 7 0 7", ec_log[7], ec_log[8], ec_log[79]);
    end
    checks++;
    if ({se_log[79], se_log[80], ec_log[80]} !== {1'b1, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL basic_samp_en_fall: got en79=%b en80=%b edge80=%0d want 1 0 0", se_log[79], se_log[80], ec_log[80]);
    end
  endtask

  task automatic test_glitch();
    cur_p = 8; PRESCALE = 6'd8;
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      se_log[c] = data_samp_en;
      ec_log[c] = edge_cnt;
      if (data_valid) obs_q.push_back(ev_t'({16'(c), P_DATA, par_err, stp_err}));
      RX_IN = (c < 2) ? 1'b0 : 1'b1;
    end
    checks++;
    if ({se_log[7], ec_log[7], se_log[8], ec_log[8]} !== {1'b1, 6'd7, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL glitch_return_idle: got en7=%b e7=%0d en8=%b e8=%0d want 1 7 0 0",
               se_log[7], ec_log[7], se_log[8], ec_log[8]);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL glitch_strobe: got %0d strobes want 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if ({P_DATA, par_err, stp_err} !== {8'hA5, 2'b00}) begin
      failures++;
      $display("FAIL glitch_state: got data=%h pe=%b se=%b want a5 0 0", P_DATA, par_err, stp_err);
    end
  endtask

  task automatic test_parity();
    ev_t e, o;
    cur_p = 16; PRESCALE = 6'd16; PAR_EN = 1'b1;
`ifdef UART_RX_PARITY_EN
    PAR_TYP = 1'b0;
    exp_q.push_back(ev_t'({16'd176, 8'h3C, 1'b0, 1'b0}));
    send(64'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 180, 1'b0);
`else
    PAR_TYP = 1'b1;
    exp_q.push_back(ev_t'({16'd160, 8'h3C, 1'b0, 1'b0}));
    send(64'({1'b1, 8'h3C, 1'b0}), 10, 164, 1'b0);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL parity_ok_strobe: got cyc=%0d byte=%h pe=%b se=%b want cyc=%0d byte=%h pe=%b se=%b",
                 o.cyc, o.dat, o.pe, o.se, e.cyc, e.dat, e.pe, e.se);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL parity_ok_extra: got %0d extra strobes want 0", obs_q.size());
    end
    obs_q.delete();
`ifdef UART_RX_PARITY_EN
    send(64'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, 180, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL parity_bad_strobe: got %0d strobes want 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if ({P_DATA, par_err, stp_err} !== {8'h3C, 2'b10}) begin
      failures++;
      $display("FAIL parity_bad_flags: got data=%h pe=%b se=%b want 3c 1 0", P_DATA, par_err, stp_err);
    end
`else
    checks++;
    if (par_err !== 1'b0) begin
      failures++; $display("FAIL parity_tied_off: got pe=%b want 0", par_err);
    end
`endif
  endtask

  task automatic test_stop_err();
    cur_p = 32; PRESCALE = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
`ifdef UART_RX_PARITY_EN
    send(64'({1'b0, 1'b0, 8'h01, 1'b0}), 11, 356, 1'b0);
`else
    send(64'({1'b0, 8'h01, 1'b0}), 10, 324, 1'b0);
`endif
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL stop_err_strobe: got %0d strobes want 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if ({P_DATA, par_err, stp_err} !== {8'h3C, 2'b01}) begin
      failures++;
      $display("FAIL stop_err_flags: got data=%h pe=%b se=%b want 3c 0 1", P_DATA, par_err, stp_err);
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (stp_err !== 1'b1) begin
      failures++; $display("FAIL stop_err_held: got se=%b want 1", stp_err);
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    cur_p = 8; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    exp_q.push_back(ev_t'({16'd80, 8'h55, 1'b0, 1'b0}));
    exp_q.push_back(ev_t'({16'd160, 8'hAA, 1'b0, 1'b0}));
    send(64'({1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}), 20, 164, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_strobe: got cyc=%0d byte=%h pe=%b se=%b want cyc=%0d byte=%h pe=%b se=%b",
                 o.cyc, o.dat, o.pe, o.se, e.cyc, e.dat, e.pe, e.se);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL b2b_extra: got %0d extra strobes want 0", obs_q.size());
    end
    obs_q.delete();
    checks++;
    if ({fl_log[0], fl_log[1]} !== {2'b01, 2'b00}) begin
      failures++;
      $display("FAIL b2b_flag_clear: got t0=%b t1=%b want 01 00", fl_log[0], fl_log[1]);
    end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    cur_p = 8; PRESCALE = 6'd8; PAR_EN = 1'b0;
    send(64'({1'b1, 8'h33, 1'b0}), 10, 36, 1'b0);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err} !== 18'h0) begin
      failures++;
      $display("FAIL reset_mid_values: got %h want 0",
               {data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err});
    end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    PRESCALE = 6'd5;
    exp_q.push_back(ev_t'({16'd80, 8'h0F, 1'b0, 1'b0}));
    send(64'({1'b1, 8'h0F, 1'b0}), 10, 84, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = '0;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid_recover: got cyc=%0d byte=%h pe=%b se=%b want cyc=%0d byte=%h pe=%b se=%b",
                 o.cyc, o.dat, o.pe, o.se, e.cyc, e.dat, e.pe, e.se);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL reset_mid_extra: got %0d extra strobes want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    RST = 1'b0;
    RX_IN = 1'b1;
    PRESCALE = 6'd8;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_stop_err();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
